// File: rtl/cordic_xbar_pkg.sv
// cordic_xbar_pkg: shared types and width helpers for the CORDIC lane crossbar.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cordic_xbar_pkg;

  // Occupancy of the output stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } xbar_st_t;

  // Ceiling log2 for elaboration-time width math.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of one lane index; never narrower than one bit.
  function automatic int sel_w(input int nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

endpackage

// File: rtl/cordic_xbar_perm.sv
// cordic_xbar_perm: combinational NCH x NCH lane permutation, out-of-range index gives a zero lane.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is captured.
// Ports:
//   i_dat  NCH*W   input lanes, lane j = i_dat[j*W +: W]
//   i_sel  NCH*SW  source index of output lane k = i_sel[k*SW +: SW]
//   o_dat  NCH*W   permuted lanes
//   o_bad  1       some output lane carries an index >= NCH
module cordic_xbar_perm
  import cordic_xbar_pkg::*;
#(
  parameter  int W   = 16,
  parameter  int NCH = 4,
  localparam int SW  = sel_w(NCH)
) (
  input  logic [NCH*W-1:0]  i_dat,
  input  logic [NCH*SW-1:0] i_sel,
  output logic [NCH*W-1:0]  o_dat,
  output logic              o_bad
);

  always_comb begin
    o_dat = '0;
    o_bad = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      // Match against every legal source; an index with no match leaves the lane at zero.
      for (int j = 0; j < NCH; j++) begin
        if (i_sel[k*SW +: SW] == SW'(j)) o_dat[k*W +: W] = i_dat[j*W +: W];
      end
      if (int'(i_sel[k*SW +: SW]) >= NCH) o_bad = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_xbar_pipe.sv
// cordic_xbar_pipe: registered NCH-lane permutation crossbar between operand fetch and add/sub-shift.
// Latency: 1 cycle from accept to data_o when the stage is empty or draining that cycle.
// Backpressure: main + skid registers; in_ready_o drops only when both hold a beat (full rate otherwise).
// Optional feature macro: CORDIC_XBAR_SELCHK_EN adds the sticky sel_err_o bad-index flag.
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid_i / in_ready_o    input handshake; data_i, sel_i sampled only on accept
//   out_valid_o / out_ready_i  output handshake; data_o held stable while stalled
//   data_i, sel_i, data_o      NCH lanes of W bits, NCH indices of SW bits
//   sel_err_o                  (CORDIC_XBAR_SELCHK_EN only) sticky, set on accept of any index >= NCH
module cordic_xbar_pipe
  import cordic_xbar_pkg::*;
#(
  parameter  int W   = 16,
  parameter  int NCH = 4,
  localparam int SW  = sel_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NCH*W-1:0]  data_i,
  input  logic [NCH*SW-1:0] sel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NCH*W-1:0]  data_o
`ifdef CORDIC_XBAR_SELCHK_EN
  ,
  output logic              sel_err_o
`endif
);

  xbar_st_t         r_st, w_st_nxt;
  logic [NCH*W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic [NCH*W-1:0] w_perm;
  logic             w_bad;
  logic             w_acc, w_drn;

  cordic_xbar_perm #(.W(W), .NCH(NCH)) u_perm (
    .i_dat (data_i),
    .i_sel (sel_i),
    .o_dat (w_perm),
    .o_bad (w_bad)
  );

  assign in_ready_o  = ~rst & (r_st != FULL);
  assign out_valid_o = (r_st != EMPTY);
  assign data_o      = r_main;
  assign w_acc       = in_valid_i & in_ready_o;
  assign w_drn       = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= EMPTY;
      r_main <= '0;
      r_skid <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_main <= w_main_nxt;
      r_skid <= w_skid_nxt;
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    unique case (r_st)
      EMPTY: begin
        if (w_acc) begin
          w_main_nxt = w_perm;
          w_st_nxt   = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_drn) begin
          w_main_nxt = w_perm;
        end else if (w_acc) begin
          // Downstream stalled: park the new beat behind main so order is kept.
          w_skid_nxt = w_perm;
          w_st_nxt   = FULL;
        end else if (w_drn) begin
          w_st_nxt   = EMPTY;
        end
      end
      FULL: begin
        if (w_drn) begin
          w_main_nxt = r_skid;
          w_st_nxt   = ONE;
        end
      end
      default: w_st_nxt = EMPTY;
    endcase
  end

`ifdef CORDIC_XBAR_SELCHK_EN
  logic r_sel_err;

  always_ff @(posedge clk) begin
    if (rst)                r_sel_err <= 1'b0;
    else if (w_acc && w_bad) r_sel_err <= 1'b1;
  end

  assign sel_err_o = r_sel_err;
`else
  // Bad-index flag has no consumer in this build.
  logic w_unused_bad;
  assign w_unused_bad = w_bad;
`endif

endmodule

// File: tb/tb_cordic_xbar_pipe.sv
// tb_cordic_xbar_pipe: randomized scoreboard bench for two crossbar instances (NCH=4 and NCH=3, W=16).
// Latency: expects each accepted beat on data_o one cycle later unless stalled.
// Backpressure: random and directed out_ready stalls; order and completeness checked by queue.
module tb_cordic_xbar_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [63:0] data0;
  logic [7:0]  sel0;
  logic [47:0] data1;
  logic [5:0]  sel1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [63:0] data_o0;
  logic [47:0] data_o1;
`ifdef CORDIC_XBAR_SELCHK_EN
  logic        err0, err1;
  logic        bad1_model = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int n_pop0 = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  cordic_xbar_pipe #(.W(16), .NCH(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .data_i(data0), .sel_i(sel0), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .data_o(data_o0)
`ifdef CORDIC_XBAR_SELCHK_EN
    , .sel_err_o(err0)
`endif
  );

  cordic_xbar_pipe #(.W(16), .NCH(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .data_i(data1), .sel_i(sel1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .data_o(data_o1)
`ifdef CORDIC_XBAR_SELCHK_EN
    , .sel_err_o(err1)
`endif
  );

  // Reference: output lane k is input lane sel[k] if that lane exists, otherwise zero.
  function automatic logic [63:0] ref_perm(input logic [63:0] d, input logic [7:0] s, input int nch);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < nch; k++) begin
      idx = int'((s >> (2 * k)) & 8'd3);
      if (idx < nch) r[k*16 +: 16] = d[idx*16 +: 16];
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [7:0] s, input int nch);
    logic b;
    b = 1'b0;
    for (int k = 0; k < nch; k++) if (int'((s >> (2 * k)) & 8'd3) >= nch) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    data0 = t;
    sel0  = 8'($urandom());
    t = {$urandom(), $urandom()};
    data1 = t[47:0];
    for (int k = 0; k < 3; k++) sel1[k*2 +: 2] = 2'($urandom_range(0, 3));
  endtask

  // Monitor: sampled on the falling edge, when inputs and state for the next rising edge are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
`ifdef CORDIC_XBAR_SELCHK_EN
        bad1_model = 1'b0;
`endif
      end else begin
        if (out_valid0 && out_ready) begin
          n_pop0++;
          if (q0.size() == 0) chk("sb0_unexpected_beat", 64'd1, 64'd0);
          else chk("sb0_data", data_o0, q0.pop_front());
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) chk("sb1_unexpected_beat", 64'd1, 64'd0);
          else chk("sb1_data", {16'd0, data_o1}, q1.pop_front());
        end
        if (in_valid && in_ready0) q0.push_back(ref_perm(data0, sel0, 4));
        if (in_valid && in_ready1) begin
          q1.push_back(ref_perm({16'd0, data1}, {2'd0, sel1}, 3));
`ifdef CORDIC_XBAR_SELCHK_EN
          if (any_bad({2'd0, sel1}, 3)) bad1_model = 1'b1;
`endif
        end
      end
    end
  end

  initial begin
    int stall;
    int p;
    logic [63:0] xexp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data0 = '0; sel0 = '0; data1 = '0; sel1 = '0;

    // Reset state
    step(); step();
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_data_o", data_o0, 64'd0);
    chk("rst_in_ready_low", {63'd0, in_ready0}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready0}, 64'd1);

    // Identity
    step();
    rnd_in();
    out_ready = 1'b1; in_valid = 1'b1;
    data0 = {16'd4, 16'd3, 16'd2, 16'd1};
    sel0  = {2'd3, 2'd2, 2'd1, 2'd0};
    step();
    in_valid = 1'b0;
    chk("ident_valid", {63'd0, out_valid0}, 64'd1);
    chk("ident_data", data_o0, {16'd4, 16'd3, 16'd2, 16'd1});
    step();

    // Reverse with broadcast
    rnd_in();
    in_valid = 1'b1;
    data0 = {16'hD, 16'hC, 16'hB, 16'hA};
    sel0  = {2'd0, 2'd0, 2'd1, 2'd2};
    step();
    in_valid = 1'b0;
    chk("bcast_data", data_o0, {16'hA, 16'hA, 16'hB, 16'hC});
    step(); step();

    // Backpressure: two beats fill main and skid
    out_ready = 1'b0; in_valid = 1'b1;
    rnd_in();
    xexp = ref_perm(data0, sel0, 4);
    step();
    rnd_in();
    step();
    in_valid = 1'b0;
    chk("bp_in_ready_full", {63'd0, in_ready0}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid0}, 64'd1);
    chk("bp_head_data", data_o0, xexp);
    step();
    chk("bp_hold_ready", {63'd0, in_ready0}, 64'd0);
    chk("bp_hold_data", data_o0, xexp);
    out_ready = 1'b1;
    step(); step();
    chk("bp_drained_valid", {63'd0, out_valid0}, 64'd0);
    chk("bp_drained_ready", {63'd0, in_ready0}, 64'd1);

    // Streaming at full rate
    stall = 0;
    p = n_pop0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rnd_in();
      #1;
      if (!in_ready0) stall++;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("stream_stalls", 64'(stall), 64'd0);
    chk("stream_beats", 64'(n_pop0 - p), 64'd100);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !out_valid0 && !out_valid1) break;
      step();
    end
    chk("drain_q0_empty", 64'(q0.size()), 64'd0);
    chk("drain_q1_empty", 64'(q1.size()), 64'd0);
`ifdef CORDIC_XBAR_SELCHK_EN
    chk("selerr_nch3", {63'd0, err1}, {63'd0, bad1_model});
    chk("selerr_nch4", {63'd0, err0}, 64'd0);
`endif

    // Reset while full
    out_ready = 1'b0; in_valid = 1'b1;
    rnd_in(); step();
    rnd_in(); step();
    in_valid = 1'b0;
    chk("mid_full", {63'd0, in_ready0}, 64'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {63'd0, out_valid0}, 64'd0);
    chk("mid_rst_data", data_o0, 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, in_ready0}, 64'd1);
`ifdef CORDIC_XBAR_SELCHK_EN
    chk("mid_rst_selerr", {63'd0, err1}, 64'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_beat", {62'd0, out_valid1, out_valid0}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
